// File: rtl/divisor_pkg.sv
// Shared types and width constants for the 5-by-4-bit sequential restoring divider.
package divisor_pkg;

  localparam int unsigned LARG_DIVIDENDO = 5;
  localparam int unsigned LARG_DIVISOR   = 4;
  localparam int unsigned NUM_PASSOS     = 5;
  localparam int unsigned LARG_CNT       = 3;

  // Counter value seen during the last restoring step
  localparam logic [LARG_CNT-1:0] CNT_ULTIMO = LARG_CNT'(NUM_PASSOS - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

endpackage

// File: rtl/estagio_restauracao.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, select.
module estagio_restauracao
  import divisor_pkg::*;
(
  input  logic [LARG_DIVIDENDO-1:0] r_in,
  input  logic                      bit_in,
  input  logic [LARG_DIVISOR-1:0]   b,
  output logic [LARG_DIVIDENDO-1:0] r_out,
  output logic                      q_bit
);

  logic [LARG_DIVIDENDO-1:0] r_desl;
  logic [LARG_DIVIDENDO-1:0] b_ext;
  logic [LARG_DIVIDENDO-1:0] dif;

  // Partial remainder stays below b (at most 15) for b != 0, so dropping its MSB on shift is safe
  always_comb begin
    r_desl = {r_in[LARG_DIVIDENDO-2:0], bit_in};
    b_ext  = {1'b0, b};
    dif    = r_desl - b_ext;
    if (r_desl >= b_ext) begin
      r_out = dif;
      q_bit = 1'b1;
    end else begin
      r_out = r_desl;
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/divisor_5x4bits_seq.sv
// Sequential 5-bit / 4-bit unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN: short-circuits b=0 and flags it on div_zero.
module divisor_5x4bits_seq
  import divisor_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iniciar,
  input  logic [LARG_DIVIDENDO-1:0] a,
  input  logic [LARG_DIVISOR-1:0]   b,
  output logic [LARG_DIVIDENDO-1:0] quociente,
  output logic [LARG_DIVISOR-1:0]   resto,
  output logic                      ocupado,
  output logic                      pronto,
  output logic                      div_zero
);

  estado_t                   estado;
  logic [LARG_DIVIDENDO-1:0] a_reg;
  logic [LARG_DIVISOR-1:0]   b_reg;
  logic [LARG_DIVIDENDO-1:0] r;
  logic [LARG_DIVIDENDO-1:0] q;
  logic [LARG_CNT-1:0]       cnt;
  logic [LARG_DIVIDENDO-1:0] r_prox;
  logic                      q_bit;

  // a_reg shifts left each step so its MSB is always the next dividend bit
  estagio_restauracao u_estagio (
    .r_in   (r),
    .bit_in (a_reg[LARG_DIVIDENDO-1]),
    .b      (b_reg),
    .r_out  (r_prox),
    .q_bit  (q_bit)
  );

`ifndef DIV_ZERO_DETECT_EN
  assign div_zero = 1'b0;
`endif

  // Control FSM with registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= OCIOSO;
      a_reg     <= '0;
      b_reg     <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      quociente <= '0;
      resto     <= '0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      pronto <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (iniciar) begin
            a_reg   <= a;
            b_reg   <= b;
            r       <= '0;
            q       <= '0;
            cnt     <= '0;
            ocupado <= 1'b1;
            estado  <= CALCULA;
          end
        end
        CALCULA: begin
`ifdef DIV_ZERO_DETECT_EN
          if (b_reg == '0) begin
            // a_reg is still unshifted here, so its low bits are the original dividend
            quociente <= '1;
            resto     <= a_reg[LARG_DIVISOR-1:0];
            div_zero  <= 1'b1;
            ocupado   <= 1'b0;
            estado    <= FIM;
          end else
`endif
          begin
            r     <= r_prox;
            q     <= {q[LARG_DIVIDENDO-2:0], q_bit};
            a_reg <= {a_reg[LARG_DIVIDENDO-2:0], 1'b0};
            cnt   <= cnt + LARG_CNT'(1);
            if (cnt == CNT_ULTIMO) begin
              quociente <= {q[LARG_DIVIDENDO-2:0], q_bit};
              resto     <= r_prox[LARG_DIVISOR-1:0];
`ifdef DIV_ZERO_DETECT_EN
              div_zero  <= 1'b0;
`endif
              ocupado   <= 1'b0;
              estado    <= FIM;
            end
          end
        end
        FIM: begin
          pronto <= 1'b1;
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/divisor_5x4bits_seq.md
DIVISOR_5X4BITS_SEQ -- requirements
Module: divisor_5x4bits_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port iniciar, input, 1 bit: start request, sampled on a rising clk edge.
REQ-004 SHALL have port a, input, 5 bits: unsigned dividend.
REQ-005 SHALL have port b, input, 4 bits: unsigned divisor.
REQ-006 SHALL have port quociente, output, 5 bits: unsigned quotient.
REQ-007 SHALL have port resto, output, 4 bits: unsigned remainder.
REQ-008 SHALL have port ocupado, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port pronto, output, 1 bit: one-cycle pulse when results become valid.
REQ-010 SHALL have port div_zero, output, 1 bit: divisor was zero on the last accepted operation.

Function
REQ-011 SHALL implement an FSM with states OCIOSO, CALCULA and FIM.
REQ-012 SHALL, in OCIOSO with iniciar=1, latch a and b, clear the partial remainder and step counter, and enter CALCULA.
REQ-013 SHALL perform one restoring step per CALCULA cycle, MSB of a first: r = {r,next a bit}; if r >= b then r = r-b and q bit = 1, else q bit = 0.
REQ-014 SHALL hold the partial remainder at 5 bits internally and SHALL never exceed 5 steps.
REQ-015 SHALL move CALCULA->FIM after exactly 5 steps; FIM SHALL last one cycle, then return to OCIOSO.
REQ-016 SHALL meet this latency: start accepted at edge k; ocupado high from edge k to edge k+5; pronto high for the one cycle after edge k+6.
REQ-017 SHALL update quociente, resto and div_zero only on entry to FIM, and SHALL hold them until the next FIM or reset.
REQ-018 SHALL ignore iniciar in CALCULA and FIM; a start request SHALL never be queued.
REQ-019 SHALL keep the latched operands stable, so that a and b changing during CALCULA do not affect the result.
REQ-020 SHALL produce a result satisfying a = quociente*b + resto with resto < b for every b != 0.

Reset
REQ-021 SHALL, on rst=1 at any time including mid-operation, abort the operation, enter OCIOSO, and drive quociente=0, resto=0, ocupado=0, pronto=0 and div_zero=0.
REQ-022 SHALL accept iniciar on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL, when macro DIV_ZERO_DETECT_EN is defined and b=0 is latched, go OCIOSO->CALCULA->FIM with no steps and set quociente=5'b11111, resto=a[3:0] and div_zero=1.
REQ-024 SHALL, without DIV_ZERO_DETECT_EN, treat b=0 by the normal 5-step algorithm, giving quociente=5'b11111 and resto=a[3:0], with div_zero tied to 0.

Structure
REQ-025 SHALL define the FSM state typedef and width constants (dividend 5, divisor 4, step count 5) in shared package divisor_pkg.
REQ-026 SHALL place one restoring step (shift-in, 5-bit subtract, compare, select) in sub-module estagio_restauracao, instantiated once.

Verification
REQ-027 SHALL check a=23, b=4, start -> pronto 6 cycles later with quociente=5, resto=3 and div_zero=0.
REQ-028 SHALL check a=31, b=1 -> quociente=31, resto=0; and a=7, b=9 -> quociente=0, resto=7.
REQ-029 SHALL check a=19, b=0 -> quociente=31, resto=3; with DIV_ZERO_DETECT_EN: pronto 2 cycles after start and div_zero=1; without it: pronto after 6 cycles and div_zero=0.
REQ-030 SHALL check iniciar pulsed again 2 cycles into a 23/4 operation -> ignored, single pronto, result 5/3 unchanged.
REQ-031 SHALL check rst asserted 3 cycles into an operation -> all outputs immediately 0, no pronto, and a new start then completes correctly.
